// File: rtl/rv_ctrl_pkg.sv
// Purpose: shared types and encodings for the multicycle RV64I-subset control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state enum with fixed debug codes, opcode/funct3 constants,
// ALU selector values, mux-select encodings, and the decoded instruction class.
package rv_ctrl_pkg;

  typedef enum logic [6:0] {
    S_RESET      = 7'd0,
    S_FETCH      = 7'd1,
    S_FETCH_WAIT = 7'd2,
    S_DECODE     = 7'd3,
    S_EX_R       = 7'd4,
    S_EX_I       = 7'd5,
    S_ADDR       = 7'd6,
    S_LD_MEM     = 7'd7,
    S_LD_WAIT    = 7'd8,
    S_LD_WB      = 7'd9,
    S_SD_MEM     = 7'd10,
    S_BRANCH     = 7'd11,
    S_LUI        = 7'd12,
    S_JAL        = 7'd13,
    S_WB_ALU     = 7'd14,
    S_HALT       = 7'd127
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_DW  = 3'b011;  // doubleword ld/sd
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;

  localparam logic [1:0] ALUB_B   = 2'b00;
  localparam logic [1:0] ALUB_4   = 2'b01;
  localparam logic [1:0] ALUB_IMM = 2'b10;

  localparam logic [1:0] PCS_INC    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;
  localparam logic [1:0] M2R_IMM = 2'b11;

  // Branches are split by condition so the FSM never needs funct3 itself.
  typedef enum logic [3:0] {
    C_BAD, C_R, C_I, C_LD, C_SD, C_BEQ, C_BNE, C_LUI, C_JAL
  } iclass_t;

endpackage

// File: rtl/decod_instr.sv
// Purpose: classify the latched instruction word for the control FSM.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows instr directly.
// Ports: instr (IR contents) in; iclass, is_sub (R-type SUB), illegal
// (unknown opcode, or known opcode with an unsupported funct3) out.
module decod_instr
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     iclass,
  output logic        is_sub,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  // Register/immediate fields belong to the datapath, not to control.
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    iclass  = C_BAD;
    is_sub  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        iclass  = C_R;
        is_sub  = instr[30];
        illegal = (funct3 != F3_ADD);
      end
      OP_IMM: begin
        iclass  = C_I;
        illegal = (funct3 != F3_ADD);
      end
      OP_LOAD: begin
        iclass  = C_LD;
        illegal = (funct3 != F3_DW);
      end
      OP_STORE: begin
        iclass  = C_SD;
        illegal = (funct3 != F3_DW);
      end
      OP_BRANCH: begin
        // A bad funct3 still lands in BRANCH; illegal then diverts to HALT.
        iclass  = (funct3 == F3_BNE) ? C_BNE : C_BEQ;
        illegal = (funct3 != F3_BEQ) && (funct3 != F3_BNE);
      end
      OP_LUI:  iclass = C_LUI;
      OP_JAL:  iclass = C_JAL;
      default: begin
        iclass  = C_BAD;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/unidade_controle_mc.sv
// Purpose: multicycle control FSM driving every datapath strobe and mux select.
// Latency: 4 to 7 cycles per instruction including FETCH; outputs decode the state register.
// Backpressure: none; memories are assumed to answer within the fixed wait states.
// Ports: clock, reset (sync, active-high), instr, alu_zero in; estado (debug state
// code), memory/register strobes, ALU and mux selects, excecao (sticky illegal) out.
module unidade_controle_mc
  import rv_ctrl_pkg::*;
#(
  parameter int STATE_W = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               alu_zero,
  output logic [STATE_W-1:0] estado,
  output logic               IMemRead,
  output logic               LoadIR,
  output logic               PCWrite,
  output logic               LoadA,
  output logic               LoadB,
  output logic               LoadAluOut,
  output logic               LoadMDR,
  output logic               DMemWrite,
  output logic               RegWrite,
  output logic               AluSrcA,
  output logic [1:0]         AluSrcB,
  output logic [2:0]         AluOp,
  output logic [1:0]         PCSource,
  output logic [1:0]         MemToReg,
  output logic               excecao
);

  state_t  state;
  iclass_t iclass;
  logic    is_sub;
  logic    illegal;

  decod_instr u_decod (
    .instr   (instr),
    .iclass  (iclass),
    .is_sub  (is_sub),
    .illegal (illegal)
  );

  assign estado = STATE_W'(state);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET:      state <= S_FETCH;
        S_FETCH:      state <= S_FETCH_WAIT;
        S_FETCH_WAIT: state <= S_DECODE;
        S_DECODE: begin
          case (iclass)
            C_R:          state <= S_EX_R;
            C_I:          state <= S_EX_I;
            C_LD, C_SD:   state <= S_ADDR;
            C_BEQ, C_BNE: state <= S_BRANCH;
            C_LUI:        state <= S_LUI;
            C_JAL:        state <= S_JAL;
            default:      state <= S_HALT;
          endcase
        end
        S_EX_R, S_EX_I: state <= illegal ? S_HALT : S_WB_ALU;
        S_ADDR: begin
          if (illegal)           state <= S_HALT;
          else if (iclass == C_SD) state <= S_SD_MEM;
          else                   state <= S_LD_MEM;
        end
        S_LD_MEM:  state <= S_LD_WAIT;
        S_LD_WAIT: state <= S_LD_WB;
        S_BRANCH:  state <= illegal ? S_HALT : S_FETCH;
        S_LD_WB, S_SD_MEM, S_LUI, S_JAL, S_WB_ALU: state <= S_FETCH;
        S_HALT:    state <= S_HALT;
        default:   state <= S_RESET;
      endcase
    end
  end

  // Execute states with an unsupported funct3 assert nothing, so a bad
  // instruction never disturbs the AluOut register, memory, regfile or PC.
  always_comb begin
    IMemRead   = 1'b0;
    LoadIR     = 1'b0;
    PCWrite    = 1'b0;
    LoadA      = 1'b0;
    LoadB      = 1'b0;
    LoadAluOut = 1'b0;
    LoadMDR    = 1'b0;
    DMemWrite  = 1'b0;
    RegWrite   = 1'b0;
    AluSrcA    = 1'b0;
    AluSrcB    = ALUB_B;
    AluOp      = ALU_NOP;
    PCSource   = PCS_INC;
    MemToReg   = M2R_ALU;
    excecao    = 1'b0;
    case (state)
      S_FETCH: IMemRead = 1'b1;
      S_FETCH_WAIT: begin
        IMemRead = 1'b1;
        LoadIR   = 1'b1;
      end
      S_DECODE: begin
        // Branch/jump target PC + imm is precomputed here into AluOut.
        LoadA      = 1'b1;
        LoadB      = 1'b1;
        LoadAluOut = 1'b1;
        AluSrcA    = 1'b0;
        AluSrcB    = ALUB_IMM;
        AluOp      = ALU_ADD;
      end
      S_EX_R: begin
        if (!illegal) begin
          AluSrcA    = 1'b1;
          AluSrcB    = ALUB_B;
          AluOp      = is_sub ? ALU_SUB : ALU_ADD;
          LoadAluOut = 1'b1;
        end
      end
      S_EX_I, S_ADDR: begin
        if (!illegal) begin
          AluSrcA    = 1'b1;
          AluSrcB    = ALUB_IMM;
          AluOp      = ALU_ADD;
          LoadAluOut = 1'b1;
        end
      end
      S_WB_ALU: begin
        RegWrite = 1'b1;
        MemToReg = M2R_ALU;
        PCWrite  = 1'b1;
        PCSource = PCS_INC;
      end
      S_LD_WAIT: LoadMDR = 1'b1;
      S_LD_WB: begin
        RegWrite = 1'b1;
        MemToReg = M2R_MDR;
        PCWrite  = 1'b1;
        PCSource = PCS_INC;
      end
      S_SD_MEM: begin
        DMemWrite = 1'b1;
        PCWrite   = 1'b1;
        PCSource  = PCS_INC;
      end
      S_BRANCH: begin
        if (!illegal) begin
          AluSrcA = 1'b1;
          AluSrcB = ALUB_B;
          AluOp   = ALU_SUB;
          PCWrite = 1'b1;
          // Only Mealy output: taken-ness comes straight from the live ALU flag.
          if ((iclass == C_BEQ && alu_zero) || (iclass == C_BNE && !alu_zero))
            PCSource = PCS_ALUOUT;
        end
      end
      S_LUI: begin
        RegWrite = 1'b1;
        MemToReg = M2R_IMM;
        PCWrite  = 1'b1;
        PCSource = PCS_INC;
      end
      S_JAL: begin
        RegWrite = 1'b1;
        MemToReg = M2R_PC4;
        PCWrite  = 1'b1;
        PCSource = PCS_ALUOUT;
      end
      // HALT is absorbing until reset, so excecao stays set for as long as it must.
      S_HALT: excecao = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_mc.sv
module tb_unidade_controle_mc;

  logic        clock;
  logic        reset;
  logic [31:0] instr;
  logic        alu_zero;
  logic [6:0]  estado;
  logic        IMemRead, LoadIR, PCWrite, LoadA, LoadB, LoadAluOut, LoadMDR;
  logic        DMemWrite, RegWrite, AluSrcA, excecao;
  logic [1:0]  AluSrcB, PCSource, MemToReg;
  logic [2:0]  AluOp;

  int n_chk  = 0;
  int n_pass = 0;

  unidade_controle_mc #(.STATE_W(7)) dut (
    .clock(clock), .reset(reset), .instr(instr), .alu_zero(alu_zero),
    .estado(estado), .IMemRead(IMemRead), .LoadIR(LoadIR), .PCWrite(PCWrite),
    .LoadA(LoadA), .LoadB(LoadB), .LoadAluOut(LoadAluOut), .LoadMDR(LoadMDR),
    .DMemWrite(DMemWrite), .RegWrite(RegWrite), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .AluOp(AluOp), .PCSource(PCSource),
    .MemToReg(MemToReg), .excecao(excecao)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One reset cycle, then release: leaves the DUT sitting in FETCH.
  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    instr = 32'h0;
    alu_zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (estado !== 7'd0 || IMemRead !== 1'b0 || LoadIR !== 1'b0 || PCWrite !== 1'b0 ||
          RegWrite !== 1'b0 || excecao !== 1'b0)
        $display("FAIL reset_hold[%0d] estado=%0d imem=%b ir=%b pcw=%b rw=%b exc=%b exp 0 with all strobes 0",
                 i, estado, IMemRead, LoadIR, PCWrite, RegWrite, excecao);
      else n_pass++;
    end
    reset = 1'b0;
    tick();
    n_chk++;
    if (estado !== 7'd1 || IMemRead !== 1'b1 || LoadIR !== 1'b0)
      $display("FAIL reset_fetch estado=%0d imem=%b ir=%b exp 1/1/0", estado, IMemRead, LoadIR);
    else n_pass++;
    tick();
    n_chk++;
    if (estado !== 7'd2 || IMemRead !== 1'b1 || LoadIR !== 1'b1)
      $display("FAIL reset_fetch_wait estado=%0d imem=%b ir=%b exp 2/1/1", estado, IMemRead, LoadIR);
    else n_pass++;
    tick();
    n_chk++;
    if (estado !== 7'd3 || IMemRead !== 1'b0 || LoadIR !== 1'b0 || LoadA !== 1'b1 ||
        LoadB !== 1'b1 || LoadAluOut !== 1'b1 || AluSrcA !== 1'b0 ||
        AluSrcB !== 2'b10 || AluOp !== 3'b001)
      $display("FAIL reset_decode estado=%0d imem=%b ir=%b la=%b lb=%b lao=%b srca=%b srcb=%b op=%b exp 3 0 0 1 1 1 0 10 001",
               estado, IMemRead, LoadIR, LoadA, LoadB, LoadAluOut, AluSrcA, AluSrcB, AluOp);
    else n_pass++;
  endtask

  task automatic test_add;
    int exp_s [5];
    int pcw;
    exp_s = '{1, 2, 3, 4, 14};
    pcw = 0;
    instr = 32'h002081B3;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (estado !== exp_s[i])
        $display("FAIL add_seq[%0d] estado=%0d exp %0d", i, estado, exp_s[i]);
      else n_pass++;
      if (PCWrite === 1'b1) pcw++;
      if (i == 3) begin
        n_chk++;
        if (AluOp !== 3'b001 || LoadAluOut !== 1'b1 || AluSrcA !== 1'b1 || AluSrcB !== 2'b00)
          $display("FAIL add_ex op=%b lao=%b srca=%b srcb=%b exp 001 1 1 00", AluOp, LoadAluOut, AluSrcA, AluSrcB);
        else n_pass++;
      end
      if (i == 4) begin
        n_chk++;
        if (RegWrite !== 1'b1 || PCSource !== 2'b00 || MemToReg !== 2'b00 || PCWrite !== 1'b1)
          $display("FAIL add_wb rw=%b pcs=%b m2r=%b pcw=%b exp 1 00 00 1", RegWrite, PCSource, MemToReg, PCWrite);
        else n_pass++;
      end
      tick();
    end
    n_chk++;
    if (estado !== 7'd1 || pcw != 1)
      $display("FAIL add_end estado=%0d pcwrites=%0d exp 1 and 1", estado, pcw);
    else n_pass++;
  endtask

  task automatic test_sub;
    instr = 32'h402081B3;
    do_reset();
    repeat (3) tick();
    n_chk++;
    if (estado !== 7'd4 || AluOp !== 3'b010)
      $display("FAIL sub_ex estado=%0d op=%b exp 4 010", estado, AluOp);
    else n_pass++;
  endtask

  task automatic test_ld;
    int exp_s [7];
    int pcw;
    exp_s = '{1, 2, 3, 6, 7, 8, 9};
    pcw = 0;
    instr = 32'h0000B183;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      n_chk++;
      if (estado !== exp_s[i])
        $display("FAIL ld_seq[%0d] estado=%0d exp %0d", i, estado, exp_s[i]);
      else n_pass++;
      if (PCWrite === 1'b1) pcw++;
      if (i == 5) begin
        n_chk++;
        if (LoadMDR !== 1'b1 || RegWrite !== 1'b0)
          $display("FAIL ld_wait mdr=%b rw=%b exp 1 0", LoadMDR, RegWrite);
        else n_pass++;
      end
      if (i == 6) begin
        n_chk++;
        if (MemToReg !== 2'b01 || RegWrite !== 1'b1 || PCSource !== 2'b00)
          $display("FAIL ld_wb m2r=%b rw=%b pcs=%b exp 01 1 00", MemToReg, RegWrite, PCSource);
        else n_pass++;
      end
      tick();
    end
    n_chk++;
    if (estado !== 7'd1 || pcw != 1)
      $display("FAIL ld_end estado=%0d pcwrites=%0d exp 1 and 1", estado, pcw);
    else n_pass++;
  endtask

  task automatic test_sd;
    instr = 32'h0030B023;
    do_reset();
    repeat (4) tick();
    n_chk++;
    if (estado !== 7'd10 || DMemWrite !== 1'b1 || PCWrite !== 1'b1 || RegWrite !== 1'b0)
      $display("FAIL sd_mem estado=%0d dmw=%b pcw=%b rw=%b exp 10 1 1 0", estado, DMemWrite, PCWrite, RegWrite);
    else n_pass++;
    tick();
    n_chk++;
    if (estado !== 7'd1)
      $display("FAIL sd_end estado=%0d exp 1", estado);
    else n_pass++;
  endtask

  task automatic test_branch;
    logic [31:0] ops [2];
    logic        taken_zero [2];
    ops = '{32'h00208463, 32'h00209463};  // beq, bne
    taken_zero = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      instr = ops[k];
      alu_zero = 1'b0;
      do_reset();
      repeat (3) tick();
      n_chk++;
      if (estado !== 7'd11 || AluOp !== 3'b010 || AluSrcA !== 1'b1)
        $display("FAIL br%0d_state estado=%0d op=%b srca=%b exp 11 010 1", k, estado, AluOp, AluSrcA);
      else n_pass++;
      for (int z = 0; z < 2; z++) begin
        alu_zero = z[0];
        #1;
        n_chk++;
        if (PCWrite !== 1'b1 || PCSource !== ((z[0] == taken_zero[k]) ? 2'b01 : 2'b00))
          $display("FAIL br%0d_zero%0d pcw=%b pcs=%b exp 1 %b", k, z, PCWrite, PCSource,
                   (z[0] == taken_zero[k]) ? 2'b01 : 2'b00);
        else n_pass++;
      end
      tick();
      n_chk++;
      if (estado !== 7'd1)
        $display("FAIL br%0d_end estado=%0d exp 1", k, estado);
      else n_pass++;
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_lui_jal;
    instr = 32'h000011B7;
    do_reset();
    repeat (3) tick();
    n_chk++;
    if (estado !== 7'd12 || RegWrite !== 1'b1 || MemToReg !== 2'b11 || PCWrite !== 1'b1 || PCSource !== 2'b00)
      $display("FAIL lui estado=%0d rw=%b m2r=%b pcw=%b pcs=%b exp 12 1 11 1 00",
               estado, RegWrite, MemToReg, PCWrite, PCSource);
    else n_pass++;
    instr = 32'h0000006F;
    do_reset();
    repeat (3) tick();
    n_chk++;
    if (estado !== 7'd13 || RegWrite !== 1'b1 || MemToReg !== 2'b10 || PCWrite !== 1'b1 || PCSource !== 2'b01)
      $display("FAIL jal estado=%0d rw=%b m2r=%b pcw=%b pcs=%b exp 13 1 10 1 01",
               estado, RegWrite, MemToReg, PCWrite, PCSource);
    else n_pass++;
    tick();
    n_chk++;
    if (estado !== 7'd1)
      $display("FAIL jal_end estado=%0d exp 1", estado);
    else n_pass++;
  endtask

  task automatic test_bad_funct3;
    instr = 32'h00109093;  // OP-IMM with funct3 001
    do_reset();
    repeat (3) tick();
    n_chk++;
    if (estado !== 7'd5 || LoadAluOut !== 1'b0 || RegWrite !== 1'b0 || PCWrite !== 1'b0)
      $display("FAIL badf3_ex estado=%0d lao=%b rw=%b pcw=%b exp 5 0 0 0", estado, LoadAluOut, RegWrite, PCWrite);
    else n_pass++;
    tick();
    n_chk++;
    if (estado !== 7'd127 || excecao !== 1'b1)
      $display("FAIL badf3_halt estado=%0d exc=%b exp 127 1", estado, excecao);
    else n_pass++;
  endtask

  task automatic test_halt;
    instr = 32'hFFFFFFFF;
    do_reset();
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (estado !== 7'd127 || excecao !== 1'b1 || PCWrite !== 1'b0 || RegWrite !== 1'b0 ||
          IMemRead !== 1'b0 || DMemWrite !== 1'b0)
        $display("FAIL halt[%0d] estado=%0d exc=%b pcw=%b rw=%b imem=%b dmw=%b exp 127 1 0 0 0 0",
                 i, estado, excecao, PCWrite, RegWrite, IMemRead, DMemWrite);
      else n_pass++;
      tick();
    end
    reset = 1'b1;
    tick();
    n_chk++;
    if (estado !== 7'd0 || excecao !== 1'b0)
      $display("FAIL halt_reset estado=%0d exc=%b exp 0 0", estado, excecao);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_ld;
    instr = 32'h0000B183;
    do_reset();
    repeat (4) tick();
    n_chk++;
    if (estado !== 7'd7)
      $display("FAIL abort_pre estado=%0d exp 7", estado);
    else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++;
      if (estado !== 7'd0 || RegWrite !== 1'b0 || LoadMDR !== 1'b0 || PCWrite !== 1'b0)
        $display("FAIL abort[%0d] estado=%0d rw=%b mdr=%b pcw=%b exp 0 0 0 0",
                 i, estado, RegWrite, LoadMDR, PCWrite);
      else n_pass++;
    end
    reset = 1'b0;
    tick();
    n_chk++;
    if (estado !== 7'd1 || RegWrite !== 1'b0)
      $display("FAIL abort_restart estado=%0d rw=%b exp 1 0", estado, RegWrite);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    instr = 32'h0;
    alu_zero = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_ld();
    test_sd();
    test_branch();
    test_lui_jal();
    test_bad_funct3();
    test_halt();
    test_reset_mid_ld();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
